// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: widths, the canonical NOP, major opcodes
// and the fetch FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory port: req/gnt address phase, rvalid/rdata response phase.
interface instruction_fetch_unit_if #(parameter int XLEN = 32);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// Pipeline boundary register carrying instruction, PC and PC+4 with stall/flush.
// A non-stalled cycle without a load inserts a bubble (valid cleared, data held).
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            load,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid
);

    // Flush beats stall and load; stall freezes every bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!stall) begin
            valid <= load;
            if (load) begin
                instr    <= instr_in;
                pc       <= pc_in;
                pc_plus4 <= pc_plus4_in;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding request at a time, parks a
// response in a skid register while decode is stalled, and handles redirects.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall_d,
    input  logic                       flush_d,
    input  logic                       pc_src_e,
    input  logic [XLEN-1:0]            pc_target_e,
    instruction_fetch_unit_if.master   imem,
    output logic [31:0]                instr_d,
    output logic [XLEN-1:0]            pc_d,
    output logic [XLEN-1:0]            pc_plus4_d,
    output logic                       valid_d,
    output logic [6:0]                 op_d
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc_f, pc_f_nxt;
    logic            kill, kill_nxt;
    logic [31:0]     skid, skid_nxt;
    logic            req;
    logic            load;
    logic [31:0]     load_instr;

    // State, PC, kill flag and skid register; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_IDLE;
            pc_f  <= RESET_PC;
            kill  <= 1'b0;
            skid  <= NOP_INSTR;
        end else begin
            state <= state_nxt;
            pc_f  <= pc_f_nxt;
            kill  <= kill_nxt;
            skid  <= skid_nxt;
        end
    end

    // Next-state logic; a redirect overrides the sequential PC in every state.
    always_comb begin
        state_nxt  = state;
        pc_f_nxt   = pc_f;
        kill_nxt   = kill;
        skid_nxt   = skid;
        req        = 1'b0;
        load       = 1'b0;
        load_instr = imem.rdata;

        case (state)
            FETCH_IDLE: state_nxt = FETCH_REQ;
            FETCH_REQ: begin
                req = 1'b1;
                if (imem.gnt) begin
                    state_nxt = FETCH_WAIT;
                    if (pc_src_e) kill_nxt = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (imem.rvalid) begin
                    kill_nxt = 1'b0;
                    if (kill || pc_src_e) begin
                        state_nxt = FETCH_REQ;
                    end else if (!stall_d) begin
                        load      = 1'b1;
                        pc_f_nxt  = pc_f + PC_STEP;
                        state_nxt = FETCH_REQ;
                    end else begin
                        skid_nxt  = imem.rdata;
                        state_nxt = FETCH_HOLD;
                    end
                end else if (pc_src_e) begin
                    kill_nxt = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (pc_src_e) begin
                    state_nxt = FETCH_REQ;
                end else if (!stall_d) begin
                    load       = 1'b1;
                    load_instr = skid;
                    pc_f_nxt   = pc_f + PC_STEP;
                    state_nxt  = FETCH_REQ;
                end
            end
            default: state_nxt = FETCH_IDLE;
        endcase

        if (pc_src_e) pc_f_nxt = pc_target_e;
    end

    assign imem.req  = req;
    assign imem.addr = pc_f;

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall_d),
        .flush       (flush_d),
        .load        (load),
        .instr_in    (load_instr),
        .pc_in       (pc_f),
        .pc_plus4_in (pc_f + PC_STEP),
        .instr       (instr_d),
        .pc          (pc_d),
        .pc_plus4    (pc_plus4_d),
        .valid       (valid_d)
    );

    assign op_d = instr_d[6:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch unit: per-cycle vector table plus a
// reset-during-transfer sequence.
module tb_instruction_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;
    logic [6:0]  op_d;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit_if #(.XLEN(32)) imem ();

    instruction_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem        (imem.master),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .op_d        (op_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        src;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    localparam logic [31:0] I0 = 32'h0050_0093;
    localparam logic [31:0] I1 = 32'h0020_81B3;
    localparam logic [31:0] I2 = 32'h0000_A103;
    localparam logic [31:0] I3 = 32'h0011_2023;
    localparam logic [31:0] I4 = 32'hDEAD_BEEF;
    localparam logic [31:0] I5 = 32'h0000_0463;
    localparam logic [31:0] I6 = 32'h0080_006F;
    localparam logic [31:0] I7 = 32'h0010_0113;
    localparam logic [31:0] I8 = 32'hBADB_AD00;
    localparam logic [31:0] I9 = 32'h00C0_0093;
    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i,
                        input logic st, input logic fl, input logic sr, input logic [31:0] tg,
                        input logic g, input logic rv, input logic [31:0] rd,
                        input logic er, input logic [31:0] ea, input logic [31:0] ei,
                        input logic ev, input logic cp, input logic [31:0] ep, input logic [31:0] e4);
        vecs[i] = '{st, fl, sr, tg, g, rv, rd, er, ea, ei, ev, cp, ep, e4};
    endtask

    task automatic check_outputs(input string tag, input logic er, input logic [31:0] ea,
                                 input logic [31:0] ei, input logic ev, input logic cp,
                                 input logic [31:0] ep, input logic [31:0] e4);
        check({tag, " imem_req"},  {31'b0, imem.req}, {31'b0, er});
        check({tag, " imem_addr"}, imem.addr, ea);
        check({tag, " instr_d"},   instr_d, ei);
        check({tag, " op_d"},      {25'b0, op_d}, {25'b0, ei[6:0]});
        check({tag, " valid_d"},   {31'b0, valid_d}, {31'b0, ev});
        if (cp) begin
            check({tag, " pc_d"},       pc_d, ep);
            check({tag, " pc_plus4_d"}, pc_plus4_d, e4);
        end
    endtask

    initial begin
        //       st fl sr tgt           g  rv rdata | req addr          instr v  cp pc            pc4
        setv( 0, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'h0,        NOP, 0, 1, 32'h0,        32'h0);
        setv( 1, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h0,        NOP, 0, 1, 32'h0,        32'h0);
        setv( 2, 0, 0, 0, 32'h0,        0, 1, I0,    0, 32'h0,        NOP, 0, 1, 32'h0,        32'h0);
        setv( 3, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h4,        I0,  1, 1, 32'h0,        32'h4);
        setv( 4, 0, 0, 0, 32'h0,        0, 1, I1,    0, 32'h4,        I0,  0, 1, 32'h0,        32'h4);
        setv( 5, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h8,        I1,  1, 1, 32'h4,        32'h8);
        setv( 6, 0, 0, 0, 32'h0,        0, 1, I2,    0, 32'h8,        I1,  0, 1, 32'h4,        32'h8);
        setv( 7, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'hC,        I2,  1, 1, 32'h8,        32'hC);
        setv( 8, 1, 0, 0, 32'h0,        0, 1, I3,    0, 32'hC,        I2,  0, 1, 32'h8,        32'hC);
        setv( 9, 1, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'hC,        I2,  0, 1, 32'h8,        32'hC);
        setv(10, 1, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'hC,        I2,  0, 1, 32'h8,        32'hC);
        setv(11, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'hC,        I2,  0, 1, 32'h8,        32'hC);
        setv(12, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h10,       I3,  1, 1, 32'hC,        32'h10);
        setv(13, 0, 1, 1, 32'h100,      0, 0, 32'h0, 0, 32'h10,       I3,  0, 1, 32'hC,        32'h10);
        setv(14, 0, 0, 0, 32'h0,        0, 1, I4,    0, 32'h100,      NOP, 0, 0, 32'h0,        32'h0);
        setv(15, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h100,      NOP, 0, 0, 32'h0,        32'h0);
        setv(16, 0, 0, 0, 32'h0,        0, 1, I5,    0, 32'h100,      NOP, 0, 0, 32'h0,        32'h0);
        setv(17, 1, 1, 0, 32'h0,        1, 0, 32'h0, 1, 32'h104,      I5,  1, 1, 32'h100,      32'h104);
        setv(18, 1, 1, 0, 32'h0,        0, 0, 32'h0, 0, 32'h104,      NOP, 0, 0, 32'h0,        32'h0);
        setv(19, 0, 0, 0, 32'h0,        0, 1, I6,    0, 32'h104,      NOP, 0, 0, 32'h0,        32'h0);
        setv(20, 0, 1, 1, 32'hFFFFFFFC, 0, 0, 32'h0, 1, 32'h108,      I6,  1, 1, 32'h104,      32'h108);
        setv(21, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'hFFFFFFFC, NOP, 0, 0, 32'h0,        32'h0);
        setv(22, 0, 0, 0, 32'h0,        0, 1, I7,    0, 32'hFFFFFFFC, NOP, 0, 0, 32'h0,        32'h0);
        setv(23, 0, 1, 1, 32'h200,      1, 0, 32'h0, 1, 32'h0,        I7,  1, 1, 32'hFFFFFFFC, 32'h0);
        setv(24, 0, 0, 0, 32'h0,        0, 1, I8,    0, 32'h200,      NOP, 0, 0, 32'h0,        32'h0);
        setv(25, 0, 0, 0, 32'h0,        1, 0, 32'h0, 1, 32'h200,      NOP, 0, 0, 32'h0,        32'h0);
        setv(26, 0, 0, 0, 32'h0,        0, 1, I9,    0, 32'h200,      NOP, 0, 0, 32'h0,        32'h0);
        setv(27, 0, 0, 0, 32'h0,        0, 0, 32'h0, 1, 32'h204,      I9,  1, 1, 32'h200,      32'h204);

        rst_n = 1'b0;
        stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;

        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, 32'h0, NOP, 1'b0, 1'b1, 32'h0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
                          vecs[i].e_valid, vecs[i].chk_pc, vecs[i].e_pc, vecs[i].e_pc4);
            stall_d     = vecs[i].stall;
            flush_d     = vecs[i].flush;
            pc_src_e    = vecs[i].src;
            pc_target_e = vecs[i].tgt;
            imem.gnt    = vecs[i].gnt;
            imem.rvalid = vecs[i].rvalid;
            imem.rdata  = vecs[i].rdata;
            @(negedge clk);
        end

        // Reset while a response is outstanding; a stray rvalid after release is ignored.
        stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; imem.rvalid = 1'b0;
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0;
        check("pre-reset in WAIT req", {31'b0, imem.req}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_outputs("async reset", 1'b0, 32'h0, NOP, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("post-reset REQ", 1'b1, 32'h0, NOP, 1'b0, 1'b1, 32'h0, 32'h0);
        imem.rvalid = 1'b1; imem.rdata = I4;
        @(negedge clk);
        imem.rvalid = 1'b0;
        check_outputs("stray rvalid", 1'b1, 32'h0, NOP, 1'b0, 1'b1, 32'h0, 32'h0);
        imem.gnt = 1'b1;
        @(negedge clk);
        imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = I0;
        check("first fetch WAIT req", {31'b0, imem.req}, 32'h0);
        @(negedge clk);
        imem.rvalid = 1'b0;
        check_outputs("first fetch", 1'b1, 32'h4, I0, 1'b1, 1'b1, 32'h0, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
